prim_sram_responder: RTL and testbench
======================================

# prim_sram_responder

Single-port SRAM responder that terminates the SRAM side of the N:1 SRAM arbiter. It accepts one request per cycle on `sram_req_i`/`sram_addr_i`/`sram_write_i`/`sram_wdata_i`, and returns read data, a one-cycle `sram_rvalid_o` pulse and `sram_rerror_o` after a fixed, fully pipelined latency. It owns the storage array, zero-initialises it after reset with an internal FSM, and flags out-of-range and not-yet-initialised accesses.

## Interface
- `SramDw`, 32: data width in bits, excluding any parity bit.
- `SramAw`, 12: address width in bits.
- `Depth`, 4096: number of words; 1..2^SramAw.
- `Latency`, 1: read latency in cycles; legal range 1..4. Illegal values fail an elaboration assertion.
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset; one clock; reset is synchronous and active-low.
- `sram_req_i` input 1: request valid. Always accepted; there is no ready signal.
- `sram_addr_i` input SramAw: word address.
- `sram_write_i` input 1: 1 = write, 0 = read.
- `sram_wdata_i` input SramDw: write data.
- `sram_rvalid_o` output 1: one-cycle pulse per completed read.
- `sram_rdata_o` output SramDw: read data; qualified by `sram_rvalid_o`, 0 otherwise.
- `sram_rerror_o` output 2: bit 0 = correctable (always 0); bit 1 = uncorrectable. Qualified by `sram_rvalid_o`.
- `init_done_o` output 1: high once the array has been zeroed.
- `err_inject_i` input 1: present only with `PRIM_SRAM_PARITY_EN`. See Configuration.

## Operation
- FSM states are INIT and READY. Reset enters INIT with `init_cnt` = 0.
- INIT: the block writes 0 to word `init_cnt` each cycle and increments the counter. On the cycle it writes word Depth-1, it moves to READY and `init_done_o` rises.
- Requests during INIT:
  - A read completes normally in time but returns `rdata` 0 with `rerror` 2'b10.
  - A write is dropped.
  - Neither disturbs `init_cnt`.
- READY, write with `sram_addr_i` < Depth: the memory is updated at the clock edge. No rvalid is produced.
- READY, read with `sram_addr_i` < Depth: the array is read and the result enters the response pipeline with `rerror` 2'b00.
- Any access with `sram_addr_i` >= Depth:
  - A write is dropped.
  - A read returns `rdata` 0 with `rerror` 2'b10.
- Response pipeline: a Latency-stage shift register of {valid, rdata, rerror}. Every cycle it accepts a new entry, so back-to-back reads produce back-to-back rvalid pulses in request order.
- Read-after-write:
  - A write in cycle t followed by a read of the same address in cycle t+1 returns the new data.
  - The single port means a read and a write never coincide.
- Memory contents are not affected by `rst_ni` directly. They are zeroed only by the INIT sweep.

## Timing
- Reset values:
  - `sram_rvalid_o` 0, `sram_rdata_o` 0, `sram_rerror_o` 0, `init_done_o` 0.
  - All pipeline stages invalid, `init_cnt` 0, FSM in INIT.
- Read issued in cycle t: `sram_rvalid_o` is high in cycle t+Latency for exactly one cycle.
- Throughput: one request per cycle, with no bubbles.
- INIT duration: `init_done_o` goes high exactly Depth cycles after the first cycle with `rst_ni` = 1.
- Reset asserted mid-operation:
  - In-flight reads are discarded, with no rvalid after reset.
  - INIT restarts from address 0, even if the previous INIT was partially complete.
- Counter width is clog2(Depth)+1 bits, so no wrap occurs before the transition to READY.

## Configuration
- Macro `PRIM_SRAM_PARITY_EN`.
- Defined:
  - Each word stores one extra even-parity bit over its data. The INIT sweep writes parity 0.
  - On a write, when `err_inject_i` = 1, the stored parity bit is inverted.
  - Reads recompute parity. A mismatch sets `rerror` bit 1 (2'b10); `rdata` is returned unchanged.
  - `err_inject_i` port exists.
- Not defined:
  - No parity storage and no `err_inject_i` port.
  - `rerror` bit 1 is set only by the INIT and out-of-range cases.

## Test plan
- Reset release with Depth=16: `init_done_o` rises 16 cycles later. Then read addresses 0..15 back-to-back -> 16 consecutive rvalid pulses, rdata 0, rerror 0.
- Latency=3: write 0xDEADBEEF to address 5 in cycle t, read address 5 in cycle t+1 -> rvalid in cycle t+4, rdata 0xDEADBEEF.
- Read during INIT (Depth=16, cycle 3 after reset) -> rdata 0, rerror 2'b10. A write to address 2 during INIT is dropped: after READY, reading address 2 returns 0.
- Depth=12, SramAw=4: write 0x1 to address 13, then read address 13 -> rdata 0, rerror 2'b10. Addresses 0..11 are unchanged.
- Issue 3 reads with Latency=4, then pulse `rst_ni` low for one cycle before they complete -> no rvalid appears, and INIT restarts, taking Depth cycles.
- With `PRIM_SRAM_PARITY_EN`: write 0x0000_0003 with `err_inject_i`=1 to address 7, then read it -> rdata 0x3, rerror 2'b10. Rewrite without injection, then read -> rerror 2'b00.

Source files
------------

// File: rtl/prim_sram_responder_if.sv
// SRAM request/response bundle between the arbiter side (master) and the responder (slave).
// err_inject_i exists only when PRIM_SRAM_PARITY_EN is defined.
interface prim_sram_responder_if #(
  parameter int SramDw = 32,
  parameter int SramAw = 12
);
  logic              sram_req_i;
  logic [SramAw-1:0] sram_addr_i;
  logic              sram_write_i;
  logic [SramDw-1:0] sram_wdata_i;
`ifdef PRIM_SRAM_PARITY_EN
  logic              err_inject_i;
`endif
  logic              sram_rvalid_o;
  logic [SramDw-1:0] sram_rdata_o;
  logic [1:0]        sram_rerror_o;

  modport master (
    output sram_req_i, sram_addr_i, sram_write_i, sram_wdata_i,
`ifdef PRIM_SRAM_PARITY_EN
    output err_inject_i,
`endif
    input  sram_rvalid_o, sram_rdata_o, sram_rerror_o
  );

  modport slave (
    input  sram_req_i, sram_addr_i, sram_write_i, sram_wdata_i,
`ifdef PRIM_SRAM_PARITY_EN
    input  err_inject_i,
`endif
    output sram_rvalid_o, sram_rdata_o, sram_rerror_o
  );
endinterface

// File: rtl/prim_sram_responder.sv
// Single-port SRAM responder: owns the array, zeroes it after reset, flags bad accesses.
// Latency: reads return after Latency cycles, fully pipelined. Backpressure: none, always accepts.
// Optional per-word even parity with error injection under PRIM_SRAM_PARITY_EN.
module prim_sram_responder #(
  parameter int SramDw  = 32,
  parameter int SramAw  = 12,
  parameter int Depth   = 4096,
  parameter int Latency = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  prim_sram_responder_if.slave  bus,
  output logic                  init_done_o
);

`ifdef PRIM_SRAM_PARITY_EN
  localparam int MemW = SramDw + 1;
`else
  localparam int MemW = SramDw;
`endif
  localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth) + 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(Depth - 1);

  if (Latency < 1 || Latency > 4) begin : gen_bad_latency
    $error("prim_sram_responder: Latency must be in 1..4");
  end
  if (Depth < 1 || Depth > (1 << SramAw)) begin : gen_bad_depth
    $error("prim_sram_responder: Depth must be in 1..2^SramAw");
  end

  typedef enum logic {StInit, StReady} state_e;

  typedef struct packed {
    logic              valid;
    logic [SramDw-1:0] rdata;
    logic [1:0]        rerror;
  } rsp_t;

  state_e            state_q, state_d;
  logic [CntW-1:0]   init_cnt_q, init_cnt_d;
  logic [MemW-1:0]   mem [Depth];
  rsp_t              pipe_q [Latency];
  rsp_t              pipe_d [Latency];
  rsp_t              rsp_new;
  logic              in_range;
  logic              mem_we;
  logic [IdxW-1:0]   mem_widx;
  logic [MemW-1:0]   mem_wdata;
  logic [MemW-1:0]   wr_word;
  logic [MemW-1:0]   rd_word;

  assign in_range = 32'(bus.sram_addr_i) < Depth;
  assign rd_word  = mem[bus.sram_addr_i[IdxW-1:0]];

`ifdef PRIM_SRAM_PARITY_EN
  // Parity sits above the data; injection flips it so the next read reports uncorrectable.
  assign wr_word = {(^bus.sram_wdata_i) ^ bus.err_inject_i, bus.sram_wdata_i};
`else
  assign wr_word = bus.sram_wdata_i;
`endif

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    mem_we     = 1'b0;
    mem_widx   = bus.sram_addr_i[IdxW-1:0];
    mem_wdata  = wr_word;
    rsp_new    = '0;
    case (state_q)
      StInit: begin
        mem_we     = 1'b1;
        mem_widx   = init_cnt_q[IdxW-1:0];
        mem_wdata  = '0;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LastIdx) begin
          state_d = StReady;
        end
        if (bus.sram_req_i && !bus.sram_write_i) begin
          rsp_new.valid  = 1'b1;
          rsp_new.rerror = 2'b10;
        end
      end
      StReady: begin
        if (bus.sram_req_i) begin
          if (bus.sram_write_i) begin
            mem_we = in_range;
          end else begin
            rsp_new.valid = 1'b1;
            if (in_range) begin
              rsp_new.rdata = rd_word[SramDw-1:0];
`ifdef PRIM_SRAM_PARITY_EN
              rsp_new.rerror = {^rd_word, 1'b0};
`endif
            end else begin
              rsp_new.rerror = 2'b10;
            end
          end
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    pipe_d[0] = rsp_new;
    for (int i = 1; i < Latency; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      for (int i = 0; i < Latency; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      for (int i = 0; i < Latency; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  // The array has no reset; it is cleared only by the INIT sweep.
  always_ff @(posedge clk_i) begin
    if (rst_ni && mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  assign bus.sram_rvalid_o = pipe_q[Latency-1].valid;
  assign bus.sram_rdata_o  = pipe_q[Latency-1].rdata;
  assign bus.sram_rerror_o = pipe_q[Latency-1].rerror;
  assign init_done_o       = (state_q == StReady);

endmodule

// File: tb/tb_prim_sram_responder.sv
// Bench for prim_sram_responder (Depth=12, SramAw=4, Latency=3) with a cycle-level model.
// Parity checks are included when PRIM_SRAM_PARITY_EN is defined.
module tb_prim_sram_responder;
  localparam int Dw  = 32;
  localparam int Aw  = 4;
  localparam int Dep = 12;
  localparam int Lat = 3;
`ifdef PRIM_SRAM_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done;
  logic inj = 1'b0;

  prim_sram_responder_if #(.SramDw(Dw), .SramAw(Aw)) bus ();

  prim_sram_responder #(
    .SramDw(Dw), .SramAw(Aw), .Depth(Dep), .Latency(Lat)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus),
    .init_done_o(init_done)
  );

`ifdef PRIM_SRAM_PARITY_EN
  assign bus.err_inject_i = inj;
`endif

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [1:0]  err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] mdl_mem [Dep];
  bit          mdl_pbad [Dep];
  int          cyc = 0;
  int          since_rel = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          armed = 1'b0;
  bit          ev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: the array is usable Dep cycles after reset release; reads land Lat cycles later.
  always @(posedge clk) begin
    if (!rst_n) begin
      armed     = 1'b1;
      since_rel = 0;
      exp_q.delete();
    end else begin
      if (bus.sram_req_i) begin
        if (bus.sram_write_i) begin
          if (since_rel >= Dep && int'(bus.sram_addr_i) < Dep) begin
            mdl_mem[int'(bus.sram_addr_i)]  = bus.sram_wdata_i;
            mdl_pbad[int'(bus.sram_addr_i)] = ParEn && inj;
          end
        end else begin
          e.due = cyc + Lat;
          if (since_rel < Dep || int'(bus.sram_addr_i) >= Dep) begin
            e.data = 32'h0;
            e.err  = 2'b10;
          end else begin
            e.data = mdl_mem[int'(bus.sram_addr_i)];
            e.err  = mdl_pbad[int'(bus.sram_addr_i)] ? 2'b10 : 2'b00;
          end
          exp_q.push_back(e);
        end
      end
      if (since_rel == Dep - 1) begin
        for (int i = 0; i < Dep; i++) begin
          mdl_mem[i]  = 32'h0;
          mdl_pbad[i] = 1'b0;
        end
      end
      since_rel++;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (armed) begin
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        chk("rsp_missed", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("rvalid", bus.sram_rvalid_o, ev);
      if (ev) begin
        chk("rdata", bus.sram_rdata_o, exp_q[0].data);
        chk("rerror", bus.sram_rerror_o, exp_q[0].err);
        void'(exp_q.pop_front());
      end else begin
        chk("rdata_idle", bus.sram_rdata_o, 0);
      end
      chk("init_done", init_done, since_rel >= Dep);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit req, input bit wr, input int a, input logic [31:0] d, input bit ij);
    bus.sram_req_i   = req;
    bus.sram_write_i = wr;
    bus.sram_addr_i  = Aw'(a);
    bus.sram_wdata_i = d;
    inj              = ij;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 0, 32'h0, 1'b0);
  endtask

  task automatic rd(input int a);
    drv(1'b1, 1'b0, a, 32'h0, 1'b0);
    tick();
  endtask

  task automatic wr(input int a, input logic [31:0] d, input bit ij);
    drv(1'b1, 1'b1, a, d, ij);
    tick();
  endtask

  int  n;
  bit  rv_seen;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_rvalid", bus.sram_rvalid_o, 0);
    chk("rst_rdata", bus.sram_rdata_o, 0);
    chk("rst_rerror", bus.sram_rerror_o, 0);
    chk("rst_init_done", init_done, 0);

    // INIT: read in cycle 3, write to address 2 in cycle 5.
    rst_n = 1'b1;
    n = 0;
    while (!init_done && n < 100) begin
      if (n == 3) drv(1'b1, 1'b0, 4, 32'h0, 1'b0);
      else if (n == 5) drv(1'b1, 1'b1, 2, 32'hAAAA_5555, 1'b0);
      else idle();
      tick();
      n++;
      if (n == 6) begin
        chk("init_rd_vld", bus.sram_rvalid_o, 1);
        chk("init_rd_err", bus.sram_rerror_o, 2'b10);
      end
    end
    idle();
    chk("init_cycles", n, Dep);

    for (int a = 0; a < Dep; a++) rd(a);
    rd(2);
    idle();
    repeat (3) tick();

    // Write then read-after-write.
    wr(5, 32'hDEAD_BEEF, 1'b0);
    rd(5);
    idle();
    tick();
    tick();
    chk("raw_vld", bus.sram_rvalid_o, 1);
    chk("raw_data", bus.sram_rdata_o, 32'hDEAD_BEEF);

    for (int a = 0; a < Dep; a++) wr(a, (a * 32'h0101_0101) ^ 32'hA5A5_0000, 1'b0);
    for (int a = Dep - 1; a >= 0; a--) rd(a);

    // Out-of-range accesses.
    wr(13, 32'h1, 1'b0);
    rd(13);
    idle();
    tick();
    tick();
    chk("oor_vld", bus.sram_rvalid_o, 1);
    chk("oor_err", bus.sram_rerror_o, 2'b10);
    chk("oor_data", bus.sram_rdata_o, 0);
    rd(12);
    rd(15);
    rd(11);
    rd(0);
    for (int a = 0; a < Dep; a++) rd(a);

    wr(3, 32'h1234_5678, 1'b0);
    rd(3);
    wr(3, 32'h8765_4321, 1'b0);
    rd(3);
    idle();
    repeat (4) tick();

    // Reset with reads in flight, then a partial INIT interrupted by another reset.
    rd(1);
    rd(2);
    drv(1'b1, 1'b0, 3, 32'h0, 1'b0);
    rst_n = 1'b0;
    tick();
    idle();
    rst_n = 1'b1;
    rv_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      rv_seen = rv_seen | bus.sram_rvalid_o;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n = 0;
    while (!init_done && n < 100) begin
      tick();
      n++;
      rv_seen = rv_seen | bus.sram_rvalid_o;
    end
    chk("reinit_cycles", n, Dep);
    chk("no_rvalid_after_rst", rv_seen, 0);

    rd(5);
    idle();
    tick();
    tick();
    chk("post_reinit_vld", bus.sram_rvalid_o, 1);
    chk("post_reinit_data", bus.sram_rdata_o, 0);

`ifdef PRIM_SRAM_PARITY_EN
    wr(7, 32'h0000_0003, 1'b1);
    rd(7);
    idle();
    tick();
    tick();
    chk("par_inj_data", bus.sram_rdata_o, 32'h3);
    chk("par_inj_err", bus.sram_rerror_o, 2'b10);
    wr(7, 32'h0000_0003, 1'b0);
    rd(7);
    idle();
    tick();
    tick();
    chk("par_clean_err", bus.sram_rerror_o, 2'b00);
`endif

    idle();
    repeat (6) tick();
    chk("drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
